// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder on the far side of the M-stage memory interface.
// A request (any read or write enable set) is captured while idle. After
// LATENCY wait cycles the access is performed on an internal word array, and
// a one-cycle data_ok strobe returns the read word and the out-of-range flag.
// While the access is outstanding a combinational stall holds the M stage.
//
// Parameters:
//   DEPTH_LOG2 : log2 of the number of 32-bit words in the array
//   LATENCY    : wait cycles between capture and response (0 is legal)
//   MEM_BASE   : byte address mapped to word 0
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous active-low reset
//   flush    in   1  cancels a pending access or blocks a new capture
//   ren      in   4  byte read enables (any set = read request)
//   wen      in   4  byte write enables (lane i <- wdata[8i+7:8i])
//   addr     in  32  byte address, addr[1:0] ignored
//   wdata    in  32  lane-aligned store data
//   rdata    out 32  read word, valid with data_ok only
//   stall    out  1  access pending
//   data_ok  out  1  one-cycle response strobe
//   err      out  1  out-of-range flag, valid with data_ok
//
// Optional build macro DMEM_ACCESS_CNT_EN adds the completed-access counters
//   rd_cnt   out 32  completed reads (including out-of-range)
//   wr_cnt   out 32  completed writes (including out-of-range)
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [3:0]  ren,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        data_ok,
    output logic        err
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Wide enough to hold LATENCY, never narrower than one bit.
    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Byte-lane merge of new store data into an existing word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lane_en);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            state_nx_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nx_s;
    logic [31:0]           addr_r;
    logic [31:0]           wdata_r;
    logic [3:0]            wen_r;
    logic                  is_wr_r;
    logic [31:0]           rdata_r;
    logic                  data_ok_r;
    logic                  err_r;
    logic [31:0]           mem_r [0:DEPTH-1];

    logic                  req_s;
    logic                  capture_s;
    logic                  exec_s;
    logic [31:0]           ex_addr_s;
    logic [31:0]           ex_wdata_s;
    logic [3:0]            ex_wen_s;
    logic                  ex_wr_s;
    logic [31:0]           offset_s;
    logic                  oor_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic [31:0]           rd_word_s;

    // Request detection, capture condition and the combinational stall.
    always_comb begin
        req_s     = (|ren) | (|wen);
        capture_s = (state_r == ST_IDLE) && req_s && !flush;
        stall     = capture_s || (state_r == ST_BUSY);
    end

    // Access fires on the capture edge when there is no wait, otherwise on the
    // edge where the counter reaches 1; a flush in BUSY always wins.
    always_comb begin
        exec_s = 1'b0;
        if (LATENCY == 0) begin
            exec_s = capture_s;
        end else begin
            exec_s = (state_r == ST_BUSY) && (cnt_r == CNT_W'(1)) && !flush;
        end
    end

    // With zero latency the access uses the live inputs, since the capture
    // registers load on the same edge.
    always_comb begin
        ex_addr_s  = addr_r;
        ex_wdata_s = wdata_r;
        ex_wen_s   = wen_r;
        ex_wr_s    = is_wr_r;
        if (state_r == ST_IDLE) begin
            ex_addr_s  = addr;
            ex_wdata_s = wdata;
            ex_wen_s   = wen;
            ex_wr_s    = |wen;
        end else begin
            ex_addr_s  = addr_r;
            ex_wdata_s = wdata_r;
            ex_wen_s   = wen_r;
            ex_wr_s    = is_wr_r;
        end
    end

    // Address decode: unsigned offset from MEM_BASE, range check, word index.
    always_comb begin
        offset_s  = ex_addr_s - MEM_BASE;
        oor_s     = (ex_addr_s < MEM_BASE) ||
                    ((offset_s >> (DEPTH_LOG2 + 2)) != 32'd0);
        idx_s     = offset_s[DEPTH_LOG2+1:2];
        rd_word_s = mem_r[idx_s];
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    state_nx_s = (LATENCY == 0) ? ST_DONE : ST_BUSY;
                    cnt_nx_s   = LAT_INIT;
                end else begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_W'(1)) begin
                    state_nx_s = ST_DONE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end else begin
                    state_nx_s = ST_BUSY;
                    cnt_nx_s   = cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Word array; contents survive reset, writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (rst && exec_s && ex_wr_s && !oor_s) begin
            mem_r[idx_s] <= merge_lanes(mem_r[idx_s], ex_wdata_s, ex_wen_s);
        end
    end

    // Control state, request capture and registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            wen_r     <= 4'd0;
            is_wr_r   <= 1'b0;
            rdata_r   <= 32'd0;
            data_ok_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if (capture_s) begin
                addr_r  <= addr;
                wdata_r <= wdata;
                wen_r   <= wen;
                is_wr_r <= |wen;
            end
            if (exec_s) begin
                // Writes (including read+write) and out-of-range reads return 0.
                data_ok_r <= 1'b1;
                err_r     <= oor_s;
                rdata_r   <= (ex_wr_s || oor_s) ? 32'd0 : rd_word_s;
            end else begin
                data_ok_r <= 1'b0;
                err_r     <= 1'b0;
                rdata_r   <= 32'd0;
            end
        end
    end

    assign rdata   = rdata_r;
    assign data_ok = data_ok_r;
    assign err     = err_r;

`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] rd_cnt_r;
    logic [31:0] wr_cnt_r;

    // Completed-access counters, bumped in the response cycle only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_r <= 32'd0;
            wr_cnt_r <= 32'd0;
        end else if (state_r == ST_DONE) begin
            if (is_wr_r) begin
                wr_cnt_r <= wr_cnt_r + 32'd1;
            end else begin
                rd_cnt_r <= rd_cnt_r + 32'd1;
            end
        end
    end

    assign rd_cnt = rd_cnt_r;
    assign wr_cnt = wr_cnt_r;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the pipeline's M-stage memory interface.
- Accepts the per-byte read enables (readEnM), per-byte write enables (writeEnM), the address (aluoutM) and the lane-merged store data (writedata_decodedM).
- Performs the access against an internal word array after a configurable wait, then returns the full read word.
- Drives a stall request back to the hazard unit while the access is outstanding.

Parameters:
- DEPTH_LOG2, 10, log2 of number of 32-bit words in the array (default 1024 words).
- LATENCY, 2, wait cycles between request capture and response; 0 is legal.
- MEM_BASE, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  exception flush; cancels an outstanding access.
- ren  in  4  byte read enables; any bit set is a read request.
- wen  in  4  byte write enables; lane i writes wdata[8i+7:8i].
- addr  in  32  byte address; word index is (addr-MEM_BASE)[DEPTH_LOG2+1:2]; addr[1:0] ignored.
- wdata  in  32  store data, already lane-aligned by the requester.
- rdata  out  32  full word read; valid only while data_ok=1.
- stall  out  1  holds the M stage while an access is pending.
- data_ok  out  1  one-cycle response strobe.
- err  out  1  out-of-range access flag; valid with data_ok.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state to IDLE, wait counter to 0, captured request to 0.
  - rdata=0, data_ok=0, err=0.
  - stall follows its combinational equation, so it is 0 unless a request is present.
  - Array contents are not reset.
- States: IDLE, BUSY, DONE.
- IDLE: req = |ren | |wen.
  - On req with flush=0: capture addr, wdata, wen, op (write if |wen else read).
  - Load counter with LATENCY; go to BUSY, or to DONE if LATENCY=0.
- ren and wen both nonzero: write wins, read ignored, rdata=0.
- BUSY:
  - Counter decrements each cycle.
  - At counter==1, the access executes on that edge and state moves to DONE.
  - Response latency: data_ok asserts exactly LATENCY+1 cycles after the capture cycle.
- Access execution:
  - Write updates only lanes with wen[i]=1; other lanes keep their contents.
  - Read registers the full addressed word into rdata.
- DONE:
  - data_ok=1 for exactly one cycle; rdata/err valid this cycle only.
  - Unconditional return to IDLE.
  - rdata and err return to 0 the following cycle.
- stall = (IDLE & req & ~flush) | BUSY. Combinational, so the requesting instruction is frozen from its first M cycle. stall=0 in DONE, so the pipeline advances in the response cycle.
- Back-to-back requests: a new request is seen in IDLE the cycle after DONE; minimum request spacing is LATENCY+2 cycles.
- Out-of-range access: (addr-MEM_BASE) >> 2 >= 2^DEPTH_LOG2, or addr < MEM_BASE.
  - Write is suppressed; read returns 0.
  - err=1 with data_ok.
- Flush:
  - flush=1 in BUSY: return to IDLE next edge, no access performed (write discarded), no data_ok.
  - flush=1 in IDLE: request not captured.
  - flush=1 in DONE: no effect; the response still pulses.
- Reset mid-access: access abandoned, no write committed unless the commit edge already occurred.
- Arithmetic: counter width is clog2(LATENCY+1), minimum 1 bit. Address subtraction is 32-bit unsigned.

Optional Feature:
- Macro DMEM_ACCESS_CNT_EN.
- When defined:
  - Adds outputs rd_cnt[31:0] and wr_cnt[31:0].
  - Each increments by 1 on each DONE cycle of a completed read or write respectively, including out-of-range accesses.
  - Flushed accesses are not counted.
  - Both reset to 0 and wrap from 32'hFFFF_FFFF to 0.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- LATENCY=2, write wen=4'b1111 addr=0x10 wdata=0xDEADBEEF -> stall high cycles 0-2, data_ok at cycle 3; then read ren=4'b1111 addr=0x10 -> rdata=0xDEADBEEF with data_ok 3 cycles after capture.
- Partial write wen=4'b0010 wdata=0x0000AB00 onto word 0xDEADBEEF -> subsequent read returns 0xDEADABEF.
- LATENCY=0, read addr=0x10 -> stall high only in capture cycle, data_ok next cycle, rdata correct.
- Write 0x12345678 issued, flush=1 in the first BUSY cycle -> no data_ok, stall drops, later read of the same address returns the prior value.
- addr=MEM_BASE+4*2^DEPTH_LOG2 write then read -> err=1 with each data_ok, read rdata=0, no in-range word modified.
- rst pulled low mid-BUSY -> data_ok=0, rdata=0 immediately; with DMEM_ACCESS_CNT_EN, after 3 reads and 2 writes complete, rd_cnt=3 and wr_cnt=2.
